uart_rx_frame: RTL
==================

UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame.
REQ-002 SHALL have input CLK, 1 bit: oversampling clock.
REQ-003 SHALL have input RST, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have input RX_IN, 1 bit: serial line, idle high.
REQ-005 SHALL have input Prescale, 6 bits: CLK cycles per bit; legal values are 8, 16 and 32.
REQ-006 SHALL have input PAR_EN, 1 bit: 1 means a parity bit follows the data bits.
REQ-007 SHALL have input PAR_TYP, 1 bit: 0 means even parity, 1 means odd parity.
REQ-008 SHALL have output P_DATA, DATA_WIDTH bits: last received data word.
REQ-009 SHALL have output Data_Valid, 1 bit: one-cycle pulse when a good frame completes.
REQ-010 SHALL have output Par_err, 1 bit: parity mismatch flag for the last frame.
REQ-011 SHALL have output Stp_err, 1 bit: stop bit sampled low in the last frame.

Function
REQ-012 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-013 SHALL use an edge counter running 0..Prescale-1 within each bit and a bit counter running 0..DATA_WIDTH-1 in DATA.
REQ-014 SHALL leave IDLE for START when it detects RX_IN low in IDLE, and SHALL clear the edge counter to 0 in that cycle.
REQ-015 SHALL capture Prescale, PAR_EN and PAR_TYP on leaving IDLE and SHALL ignore changes to them until the frame ends.
REQ-016 SHALL sample each bit at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1; the bit value is the 2-of-3 majority, registered at edge count Prescale/2+2.
REQ-017 SHALL treat a START sampled value of 1 as a glitch: return to IDLE at edge count Prescale-1, with no output change.
REQ-018 SHALL shift DATA bits in LSB first and, at edge count Prescale-1 of bit DATA_WIDTH-1, go to PARITY if PAR_EN=1, else to STOP.
REQ-019 SHALL compute, in PARITY, expected = ^data when PAR_TYP=0 and ~^data when PAR_TYP=1.
REQ-020 SHALL record a parity error when the sampled parity bit differs from the expected value, then go to STOP at edge count Prescale-1.
REQ-021 SHALL, in STOP, go to IDLE in the cycle after the stop value is registered, at edge count Prescale/2+3, so back-to-back frames are received.
REQ-022 SHALL update Par_err and Stp_err (Stp_err=1 when stop sampled 0) in the cycle STOP exits to IDLE, and SHALL hold them until the next frame exits STOP.
REQ-023 SHALL, in that same cycle and only when both errors are 0, load P_DATA with the received word and pulse Data_Valid high for exactly 1 cycle.
REQ-024 SHALL leave P_DATA unchanged on an errored frame.
REQ-025 SHALL give Data_Valid a latency of DATA_WIDTH+1+PAR_EN bit periods plus Prescale/2+3 cycles from the first low RX_IN cycle.
REQ-026 SHALL treat an illegal Prescale value as undefined behaviour; the bench SHALL NOT drive one.

Reset
REQ-027 SHALL, on RST low, immediately force the FSM to IDLE, both counters to 0, P_DATA to 0 and Data_Valid, Par_err and Stp_err to 0.
REQ-028 SHALL abandon any frame in progress when RST is asserted mid-frame, with no Data_Valid pulse.
REQ-029 SHALL, after RST deasserts, wait for RX_IN low in IDLE before starting a frame.

Configuration
REQ-030 SHALL, when macro UART_RX_MAJORITY_EN is defined, use 3-sample majority voting as described in REQ-016.
REQ-031 SHALL, when UART_RX_MAJORITY_EN is undefined, take a single sample at edge count Prescale/2, registered at the same edge count Prescale/2+2, with all timing unchanged.

Verification
REQ-032 SHALL drive Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity bit 0 and stop 1 -> P_DATA=0xA5, one Data_Valid pulse, Par_err=0, Stp_err=0.
REQ-033 SHALL drive Prescale=16, PAR_EN=1, PAR_TYP=1, frame 0x3C with parity bit 0 -> Par_err=1, no Data_Valid pulse, P_DATA keeps its previous value.
REQ-034 SHALL drive Prescale=32, PAR_EN=0, frame 0xFF with stop bit 0 -> Stp_err=1, no Data_Valid pulse; a following good frame 0x01 -> Data_Valid pulse and both errors cleared.
REQ-035 SHALL drive a 2-cycle low glitch on RX_IN at Prescale=8 -> FSM returns to IDLE, no output changes.
REQ-036 SHALL drive back-to-back frames 0x55 and 0xAA at Prescale=8 with no idle gap -> two Data_Valid pulses 80 cycles apart, P_DATA 0x55 then 0xAA.
REQ-037 SHALL assert RST in the middle of DATA bit 4 -> all outputs 0 at once, no pulse, and the next clean frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// Oversampled UART frame receiver: start, DATA_WIDTH data bits (LSB first), optional parity, stop.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting; otherwise a single mid-bit sample is used.
module uart_rx_frame #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_err,
  output logic                  Stp_err
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [5:0]            edge_q, edge_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [5:0]            presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  bit_q, bit_d;
  logic                  par_bad_q, par_bad_d;
  logic                  valid_q, valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  s_mid_q, s_mid_d;
  logic                  vote;
  logic                  par_exp;

  logic [5:0] half, last_edge, vote_edge, exit_edge;

  assign half      = {1'b0, presc_q[5:1]};
  assign last_edge = presc_q - 6'd1;
  assign vote_edge = half + 6'd2;
  assign exit_edge = half + 6'd3;
  assign par_exp   = par_typ_q ? ~^shift_q : ^shift_q;

`ifdef UART_RX_MAJORITY_EN
  logic       s_lo_q, s_lo_d, s_hi_q, s_hi_d;
  logic [5:0] smp_lo, smp_hi;
  assign smp_lo = half - 6'd1;
  assign smp_hi = half + 6'd1;
  assign vote   = (s_lo_q & s_mid_q) | (s_lo_q & s_hi_q) | (s_mid_q & s_hi_q);
`else
  assign vote   = s_mid_q;
`endif

  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q + 6'd1;
    bit_cnt_d = bit_cnt_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    shift_d   = shift_q;
    p_data_d  = p_data_q;
    bit_d     = bit_q;
    par_bad_d = par_bad_q;
    valid_d   = 1'b0;
    par_err_d = par_err_q;
    stp_err_d = stp_err_q;
    s_mid_d   = s_mid_q;
`ifdef UART_RX_MAJORITY_EN
    s_lo_d    = s_lo_q;
    s_hi_d    = s_hi_q;
`endif

    if (state_q != IDLE) begin
`ifdef UART_RX_MAJORITY_EN
      if (edge_q == smp_lo) s_lo_d = RX_IN;
      if (edge_q == smp_hi) s_hi_d = RX_IN;
`endif
      if (edge_q == half)      s_mid_d = RX_IN;
      if (edge_q == vote_edge) bit_d   = vote;
    end

    case (state_q)
      IDLE: begin
        edge_d    = 6'd0;
        bit_cnt_d = '0;
        // The detecting cycle is edge 0 of the start bit, so START resumes at edge 1.
        if (!RX_IN) begin
          state_d   = START;
          edge_d    = 6'd1;
          presc_d   = Prescale;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (edge_q == last_edge) begin
          edge_d  = 6'd0;
          state_d = bit_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (edge_q == last_edge) begin
          edge_d  = 6'd0;
          shift_d = {bit_q, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (edge_q == last_edge) begin
          edge_d    = 6'd0;
          par_bad_d = bit_q ^ par_exp;
          state_d   = STOP;
        end
      end
      STOP: begin
        // Leave early so a start bit directly after the stop bit is seen in IDLE.
        if (edge_q == exit_edge) begin
          edge_d    = 6'd0;
          state_d   = IDLE;
          par_err_d = par_bad_q;
          stp_err_d = ~bit_q;
          if (!par_bad_q && bit_q) begin
            p_data_d = shift_q;
            valid_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = 6'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      edge_q    <= 6'd0;
      bit_cnt_q <= '0;
      presc_q   <= 6'd8;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      shift_q   <= '0;
      p_data_q  <= '0;
      bit_q     <= 1'b1;
      par_bad_q <= 1'b0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      s_mid_q   <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      s_lo_q    <= 1'b1;
      s_hi_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_cnt_q <= bit_cnt_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      shift_q   <= shift_d;
      p_data_q  <= p_data_d;
      bit_q     <= bit_d;
      par_bad_q <= par_bad_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
      s_mid_q   <= s_mid_d;
`ifdef UART_RX_MAJORITY_EN
      s_lo_q    <= s_lo_d;
      s_hi_q    <= s_hi_d;
`endif
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = valid_q;
  assign Par_err    = par_err_q;
  assign Stp_err    = stp_err_q;

endmodule
